// File: rtl/pwqe_station_buffer_pkg.sv
// Shared constants, types and helpers for the pending-WQE station and its neighbours.
package pwqe_station_buffer_pkg;

   localparam int PWQE_SLOT_NUM       = 4;
   localparam int PWQE_BUF_ADDR_WIDTH = 2;
   localparam int PWQE_BUF_WIDTH      = 512;
   localparam int LEN_LSB             = 32;
   localparam int LEN_WIDTH           = 32;

   typedef logic [PWQE_SLOT_NUM-1:0]       slot_mask_t;
   typedef logic [PWQE_BUF_ADDR_WIDTH-1:0] slot_idx_t;
   typedef logic [PWQE_BUF_ADDR_WIDTH:0]   slot_cnt_t;
   typedef logic [PWQE_BUF_WIDTH-1:0]      wqe_t;

   // Fill engine: IDLE issues a pop, WAIT captures the returned WQE.
   typedef enum logic {
      FILL_IDLE = 1'b0,
      FILL_WAIT = 1'b1
   } fill_state_e;

   // Index of the lowest set bit; only meaningful when the mask is non-zero.
   function automatic slot_idx_t lowestSet(input slot_mask_t m);
      slot_idx_t idx;
      idx = '0;
      for (int i = PWQE_SLOT_NUM - 1; i >= 0; i--) begin
         if (m[i]) idx = slot_idx_t'(i);
      end
      return idx;
   endfunction

   // Number of set bits in a slot mask.
   function automatic slot_cnt_t popCount(input slot_mask_t m);
      slot_cnt_t cnt;
      cnt = '0;
      for (int i = 0; i < PWQE_SLOT_NUM; i++) begin
         cnt = cnt + slot_cnt_t'(m[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/pwqe_station_buffer_if.sv
// BS WQE FIFO side and scheduler port-1 side of the pending-WQE station.
interface pwqe_station_buffer_if;
   import pwqe_station_buffer_pkg::*;

   logic       i_bs_wqe_empty;
   logic       o_bs_wqe_ren;
   wqe_t       i_bs_wqe_rdata;
   logic       i_ren_1;
   logic       i_wen_1;
   slot_idx_t  i_addr_1;
   wqe_t       i_din_1;
   wqe_t       o_dout_1;
   slot_mask_t o_slot_status;
   slot_cnt_t  o_free_cnt;
   logic [2:0] o_err;

   // Driven by the FIFO and scheduler; observes the station's outputs.
   modport master (
      output i_bs_wqe_empty, i_bs_wqe_rdata, i_ren_1, i_wen_1, i_addr_1, i_din_1,
      input  o_bs_wqe_ren, o_dout_1, o_slot_status, o_free_cnt, o_err
   );

   // The station itself.
   modport slave (
      input  i_bs_wqe_empty, i_bs_wqe_rdata, i_ren_1, i_wen_1, i_addr_1, i_din_1,
      output o_bs_wqe_ren, o_dout_1, o_slot_status, o_free_cnt, o_err
   );

endinterface

// File: rtl/pwqe_station_buffer_slot_ram.sv
// Slot storage: a fill write port, a write-back port and one registered read port.
// The two write ports are guaranteed by the caller never to hit the same slot.
module pwqe_station_buffer_slot_ram
   import pwqe_station_buffer_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      i_fillWe,
   input  slot_idx_t i_fillAddr,
   input  wqe_t      i_fillData,
   input  logic      i_wbWe,
   input  slot_idx_t i_wbAddr,
   input  wqe_t      i_wbData,
   input  logic      i_rdEn,
   input  slot_idx_t i_rdAddr,
   output wqe_t      o_rdData
);

   wqe_t r_mem [PWQE_SLOT_NUM];
   wqe_t r_rdData;

   // Storage writes; contents are not cleared by reset because slot flags gate their use.
   always_ff @(posedge clk) begin
      if (i_fillWe) r_mem[i_fillAddr] <= i_fillData;
      if (i_wbWe)   r_mem[i_wbAddr]   <= i_wbData;
   end

   // Registered read returns the contents as they were before any same-cycle write.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdData <= '0;
      end else if (i_rdEn) begin
         r_rdData <= r_mem[i_rdAddr];
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/pwqe_station_buffer.sv
// Pending-WQE station for the bandwidth-sensitive group: refills free slots from the
// BS WQE FIFO and serves scheduler port-1 reads and write-backs.
module pwqe_station_buffer
   import pwqe_station_buffer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   pwqe_station_buffer_if.slave  io_bus
);

   fill_state_e r_state;
   fill_state_e w_nextState;
   slot_mask_t  r_valid;
   slot_mask_t  r_busy;
   slot_mask_t  r_rsvd;
   slot_idx_t   r_fillIdx;
   logic [2:0]  r_err;

   slot_mask_t  w_free;
   slot_idx_t   w_freeIdx;
   logic        w_pop;
   logic        w_fillWe;
   logic        w_rdOk;
   logic        w_wbOk;
   logic        w_wbWe;
   logic        w_wbRetire;
   wqe_t        w_dout;

   assign w_free     = ~r_valid & ~r_rsvd;
   assign w_freeIdx  = lowestSet(w_free);
   assign w_rdOk     = r_valid[io_bus.i_addr_1] & ~r_busy[io_bus.i_addr_1];
   assign w_wbOk     = r_valid[io_bus.i_addr_1] &  r_busy[io_bus.i_addr_1];
   assign w_wbWe     = io_bus.i_wen_1 & w_wbOk;
   assign w_wbRetire = (io_bus.i_din_1[LEN_LSB +: LEN_WIDTH] == '0);

   // Fill sequencing: pop when a slot is free and data exists, capture it the next cycle.
   always_comb begin
      w_nextState = r_state;
      w_pop       = 1'b0;
      w_fillWe    = 1'b0;
      case (r_state)
         FILL_IDLE: begin
            if (!io_bus.i_bs_wqe_empty && (|w_free) && !rst) begin
               w_pop       = 1'b1;
               w_nextState = FILL_WAIT;
            end
         end
         FILL_WAIT: begin
            w_fillWe    = !rst;
            w_nextState = FILL_IDLE;
         end
         default: w_nextState = FILL_IDLE;
      endcase
   end

   // Fill state register and the slot index reserved by the outstanding pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= FILL_IDLE;
         r_fillIdx <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_pop) r_fillIdx <= w_freeIdx;
      end
   end

   // Slot flags: reserve on pop, validate on fill, busy on good read, clear or retire on good write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_busy  <= '0;
         r_rsvd  <= '0;
      end else begin
         if (w_pop) r_rsvd[w_freeIdx] <= 1'b1;
         if (w_fillWe) begin
            r_valid[r_fillIdx] <= 1'b1;
            r_rsvd[r_fillIdx]  <= 1'b0;
         end
         if (io_bus.i_ren_1 && w_rdOk) r_busy[io_bus.i_addr_1] <= 1'b1;
         if (w_wbWe) begin
            r_busy[io_bus.i_addr_1] <= 1'b0;
            if (w_wbRetire) r_valid[io_bus.i_addr_1] <= 1'b0;
         end
      end
   end

   // Sticky protocol errors, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= '0;
      end else begin
         r_err <= r_err | {io_bus.i_ren_1 & io_bus.i_wen_1,
                           io_bus.i_wen_1 & ~w_wbOk,
                           io_bus.i_ren_1 & ~w_rdOk};
      end
   end

   pwqe_station_buffer_slot_ram u_slotRam (
      .clk        (clk),
      .rst        (rst),
      .i_fillWe   (w_fillWe),
      .i_fillAddr (r_fillIdx),
      .i_fillData (io_bus.i_bs_wqe_rdata),
      .i_wbWe     (w_wbWe),
      .i_wbAddr   (io_bus.i_addr_1),
      .i_wbData   (io_bus.i_din_1),
      .i_rdEn     (io_bus.i_ren_1),
      .i_rdAddr   (io_bus.i_addr_1),
      .o_rdData   (w_dout)
   );

   assign io_bus.o_bs_wqe_ren  = w_pop;
   assign io_bus.o_dout_1      = w_dout;
   assign io_bus.o_slot_status = r_valid & ~r_busy;
   assign io_bus.o_free_cnt    = popCount(w_free);
   assign io_bus.o_err         = r_err;

endmodule

// File: tb/tb_pwqe_station_buffer.sv
// Directed bench for the pending-WQE station: a FIFO model feeds fills, a scoreboard
// checks read data, and inline checks cover flags, counters and errors.
module tb_pwqe_station_buffer;
   import pwqe_station_buffer_pkg::*;

   localparam logic [31:0] LEN_FULL = 32'h0000_0100;

   logic clk;
   logic rst;

   pwqe_station_buffer_if ifc ();

   pwqe_station_buffer dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (ifc.slave)
   );

   int   nCompared   = 0;
   int   nMismatched = 0;

   wqe_t fifoMem [16];
   int   wrPtr = 0;
   int   rdPtr = 0;
   wqe_t fifoRdata = '0;
   int   cycleCnt = 0;
   int   popQ [$];
   logic pendingRd = 1'b0;
   wqe_t expQ [$];

   assign ifc.i_bs_wqe_empty = (rdPtr == wrPtr);
   assign ifc.i_bs_wqe_rdata = fifoRdata;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Build a recognisable WQE with a given remaining length.
   function automatic wqe_t mkWqe(input int id, input logic [31:0] len);
      wqe_t w;
      for (int k = 0; k < 16; k++) begin
         w[k*32 +: 32] = 32'hA500_0000 | 32'(id << 8) | 32'(k);
      end
      w[LEN_LSB +: LEN_WIDTH] = len;
      return w;
   endfunction

   // One comparison: count it, and report it when it disagrees.
   task automatic checkOutput(input string name, input wqe_t act, input wqe_t exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of scheduler port-1 activity; returns just after the sampling edge.
   task automatic applyStimulus(input logic ren, input logic wen, input int addr, input wqe_t din);
      @(negedge clk);
      ifc.i_ren_1  = ren;
      ifc.i_wen_1  = wen;
      ifc.i_addr_1 = slot_idx_t'(addr);
      ifc.i_din_1  = din;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, '0);
   endtask

   task automatic readSlot(input int addr, input wqe_t exp);
      expQ.push_back(exp);
      applyStimulus(1'b1, 1'b0, addr, '0);
   endtask

   task automatic pushFifo(input wqe_t w);
      fifoMem[wrPtr % 16] = w;
      wrPtr = wrPtr + 1;
   endtask

   // Upstream FIFO model with one-cycle read latency, plus pop-cycle logging.
   always @(posedge clk) begin
      if (rst) begin
         cycleCnt <= 0;
      end else begin
         if (ifc.o_bs_wqe_ren) begin
            fifoRdata <= fifoMem[rdPtr % 16];
            rdPtr     <= rdPtr + 1;
            popQ.push_back(cycleCnt);
         end
         cycleCnt <= cycleCnt + 1;
      end
      pendingRd <= ifc.i_ren_1 && !rst;
   end

   // Scoreboard monitor: each accepted read presents data the following cycle.
   always @(negedge clk) begin
      if (pendingRd) begin
         if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL dout_unexpected: got %0h expected no read data", ifc.o_dout_1);
         end else begin
            checkOutput("dout", ifc.o_dout_1, expQ.pop_front());
         end
      end
   end

   initial begin
      rst          = 1'b1;
      ifc.i_ren_1  = 1'b0;
      ifc.i_wen_1  = 1'b0;
      ifc.i_addr_1 = '0;
      ifc.i_din_1  = '0;
      for (int k = 1; k <= 5; k++) pushFifo(mkWqe(k, LEN_FULL));

      // Reset, then four fills every other cycle; the fifth WQE waits for space.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b0000));
      checkOutput("rst_free",   wqe_t'(ifc.o_free_cnt), wqe_t'(3'd4));
      checkOutput("rst_err",    wqe_t'(ifc.o_err), wqe_t'(3'b000));
      checkOutput("rst_dout",   ifc.o_dout_1, '0);
      @(negedge clk);
      rst = 1'b0;
      idle(9);
      checkOutput("pop_count", wqe_t'(popQ.size()), wqe_t'(4));
      for (int k = 0; k < 4; k++) begin
         checkOutput("pop_cycle", wqe_t'((k < popQ.size()) ? popQ[k] : -1), wqe_t'(2 * k));
      end
      checkOutput("full_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b1111));
      checkOutput("full_free",   wqe_t'(ifc.o_free_cnt), wqe_t'(3'd0));
      checkOutput("fifo_left",   wqe_t'(wrPtr - rdPtr), wqe_t'(1));
      checkOutput("no_pop_full", wqe_t'(ifc.o_bs_wqe_ren), wqe_t'(1'b0));

      // Read slot 2, write it back with remaining length, read the new data.
      readSlot(2, mkWqe(3, LEN_FULL));
      checkOutput("rd2_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b1011));
      applyStimulus(1'b0, 1'b1, 2, mkWqe(33, 32'h40));
      checkOutput("wb2_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b1111));
      readSlot(2, mkWqe(33, 32'h40));
      applyStimulus(1'b0, 1'b1, 2, mkWqe(33, 32'h40));
      checkOutput("wb2b_free", wqe_t'(ifc.o_free_cnt), wqe_t'(3'd0));

      // Retire slot 1 and watch the pending fifth WQE land there.
      readSlot(1, mkWqe(2, LEN_FULL));
      applyStimulus(1'b0, 1'b1, 1, mkWqe(2, 32'h0));
      checkOutput("ret1_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b1101));
      checkOutput("ret1_free",   wqe_t'(ifc.o_free_cnt), wqe_t'(3'd1));
      checkOutput("ret1_pop",    wqe_t'(ifc.o_bs_wqe_ren), wqe_t'(1'b1));
      idle(1);
      checkOutput("rsvd1_free",  wqe_t'(ifc.o_free_cnt), wqe_t'(3'd0));
      idle(1);
      checkOutput("fill1_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b1111));
      readSlot(1, mkWqe(5, LEN_FULL));
      applyStimulus(1'b0, 1'b1, 1, mkWqe(5, LEN_FULL));

      // Fill capture and a write-back to another slot in the same cycle.
      pushFifo(mkWqe(6, LEN_FULL));
      readSlot(0, mkWqe(1, LEN_FULL));
      readSlot(3, mkWqe(4, LEN_FULL));
      checkOutput("busy03_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b0110));
      applyStimulus(1'b0, 1'b1, 0, mkWqe(1, 32'h0));
      checkOutput("ret0_pop", wqe_t'(ifc.o_bs_wqe_ren), wqe_t'(1'b1));
      idle(1);
      applyStimulus(1'b0, 1'b1, 3, mkWqe(44, 32'h77));
      checkOutput("dual_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b1111));
      readSlot(0, mkWqe(6, LEN_FULL));
      applyStimulus(1'b0, 1'b1, 0, mkWqe(6, LEN_FULL));
      readSlot(3, mkWqe(44, 32'h77));
      checkOutput("busy3_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b0111));

      // Protocol errors are sticky.
      checkOutput("err_clean", wqe_t'(ifc.o_err), wqe_t'(3'b000));
      readSlot(3, mkWqe(44, 32'h77));
      checkOutput("err_badrd",  wqe_t'(ifc.o_err), wqe_t'(3'b001));
      checkOutput("badrd_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b0111));
      applyStimulus(1'b0, 1'b1, 1, mkWqe(99, 32'h1));
      checkOutput("err_badwb", wqe_t'(ifc.o_err), wqe_t'(3'b011));
      expQ.push_back(mkWqe(44, 32'h77));
      applyStimulus(1'b1, 1'b1, 3, mkWqe(55, 32'h9));
      checkOutput("err_both",  wqe_t'(ifc.o_err), wqe_t'(3'b111));
      checkOutput("both_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b1111));
      readSlot(3, mkWqe(55, 32'h9));
      readSlot(1, mkWqe(5, LEN_FULL));
      checkOutput("busy13_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b0101));
      idle(2);
      checkOutput("err_sticky", wqe_t'(ifc.o_err), wqe_t'(3'b111));

      // Reset arriving in the fill capture cycle discards the fill.
      pushFifo(mkWqe(7, LEN_FULL));
      applyStimulus(1'b0, 1'b1, 1, mkWqe(77, 32'h0));
      checkOutput("ret1b_free", wqe_t'(ifc.o_free_cnt), wqe_t'(3'd1));
      idle(1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("wrst_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b0000));
      checkOutput("wrst_free",   wqe_t'(ifc.o_free_cnt), wqe_t'(3'd4));
      checkOutput("wrst_err",    wqe_t'(ifc.o_err), wqe_t'(3'b000));
      checkOutput("wrst_ren",    wqe_t'(ifc.o_bs_wqe_ren), wqe_t'(1'b0));
      @(negedge clk);
      rst = 1'b0;
      readSlot(1, mkWqe(77, 32'h0));
      checkOutput("postrst_err", wqe_t'(ifc.o_err), wqe_t'(3'b001));
      pushFifo(mkWqe(8, LEN_FULL));
      idle(2);
      checkOutput("postrst_status", wqe_t'(ifc.o_slot_status), wqe_t'(4'b0001));
      checkOutput("postrst_free",   wqe_t'(ifc.o_free_cnt), wqe_t'(3'd3));
      readSlot(0, mkWqe(8, LEN_FULL));
      idle(2);
      checkOutput("sb_drained", wqe_t'(expQ.size()), wqe_t'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
